// File: rtl/pc_sequencer_if.sv
// Instruction-memory request channel between fetch and IM.
// Ports: im_req/im_addr (fetch->IM), im_ack/im_rdata (IM->fetch).
interface pc_sequencer_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;

  modport master (
    output im_req, im_addr,
    input  im_ack, im_rdata
  );

  modport slave (
    input  im_req, im_addr,
    output im_ack, im_rdata
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: one outstanding IM request, redirects, AdEL.
// Ports: clk, reset, stall, branch/IntReq/eret redirects, im bus, F outputs.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PC_LO      = 32'h0000_3000,
  parameter logic [31:0] PC_HI      = 32'h0000_4ffc
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [31:0]   br_target,
  input  logic          IntReq,
  input  logic          eret,
  input  logic [31:0]   EPC,
  pc_sequencer_if.master im,
  output logic [31:0]   PC_F,
  output logic [31:0]   PC8_F,
  output logic [31:0]   instr_F,
  output logic          fetch_valid,
  output logic [4:0]    ExcCodeF
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    VALID,
    EXC
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_int_q, pend_int_d;

  logic        legal;
  logic        redirect;
  logic [31:0] redir_pc;

  assign legal = (pc_q[1:0] == 2'b00)
              && (pc_q >= PC_LO)
              && (pc_q <= PC_HI);

  assign redirect = IntReq | eret;
  assign redir_pc = IntReq ? HANDLER_PC : EPC;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    pend_int_d   = pend_int_q;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d = redir_pc;
        end else if (legal) begin
          state_d = WAIT;
        end else begin
          state_d = EXC;
          instr_d = '0;
        end
      end
      WAIT: begin
        // A pending interrupt target is never displaced by eret.
        if (IntReq) begin
          pend_d       = HANDLER_PC;
          pend_valid_d = 1'b1;
          pend_int_d   = 1'b1;
        end else if (eret && !(pend_valid_q && pend_int_q)) begin
          pend_d       = EPC;
          pend_valid_d = 1'b1;
          pend_int_d   = 1'b0;
        end
        if (im.im_ack) begin
          if (pend_valid_d) begin
            pc_d         = pend_d;
            pend_valid_d = 1'b0;
            pend_int_d   = 1'b0;
            state_d      = FETCH;
          end else begin
            instr_d = im.im_rdata;
            state_d = VALID;
          end
        end
      end
      VALID, EXC: begin
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = br_taken ? br_target : pc_q + 32'd4;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_int_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      pend_int_q   <= pend_int_d;
    end
  end

  assign im.im_req  = (state_q == FETCH && legal)
                   || (state_q == WAIT);
  assign im.im_addr = pc_q;

  assign PC_F        = pc_q;
  assign PC8_F       = pc_q + 32'd8;
  assign instr_F     = instr_q;
  assign fetch_valid = (state_q == VALID)
                    || (state_q == EXC);
  assign ExcCodeF    = (state_q == EXC) ? 5'd4 : 5'd0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer.
// Drives at negedge, samples at negedge, expected values hand-derived.
module tb_pc_sequencer;
  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        IntReq;
  logic        eret;
  logic [31:0] EPC;
  logic [31:0] PC_F;
  logic [31:0] PC8_F;
  logic [31:0] instr_F;
  logic        fetch_valid;
  logic [4:0]  ExcCodeF;
  int          checks;
  int          failures;

  pc_sequencer_if im();

  pc_sequencer dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .br_taken(br_taken),
    .br_target(br_target),
    .IntReq(IntReq),
    .eret(eret),
    .EPC(EPC),
    .im(im),
    .PC_F(PC_F),
    .PC8_F(PC8_F),
    .instr_F(instr_F),
    .fetch_valid(fetch_valid),
    .ExcCodeF(ExcCodeF)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Walks one fetch from FETCH to VALID with a one-cycle ack.
  task automatic run_fetch(input logic [31:0] data);
    tick();
    im.im_ack = 1'b1;
    im.im_rdata = data;
    tick();
    im.im_ack = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (PC_F !== 32'h3000) begin
      failures++;
      $display("FAIL rst_pc got=%h exp=%h", PC_F, 32'h3000);
    end
    checks++;
    if (PC8_F !== 32'h3008) begin
      failures++;
      $display("FAIL rst_pc8 got=%h exp=%h", PC8_F, 32'h3008);
    end
    checks++;
    if (instr_F !== 32'h0) begin
      failures++;
      $display("FAIL rst_instr got=%h exp=0", instr_F);
    end
    checks++;
    if (fetch_valid !== 1'b0 || ExcCodeF !== 5'd0) begin
      failures++;
      $display("FAIL rst_fv_exc got=%b/%0d exp=0/0",
               fetch_valid, ExcCodeF);
    end
    reset = 1'b0;
    checks++;
    if (im.im_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_req got=%b exp=1", im.im_req);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] p;
    for (int k = 0; k < 3; k++) begin
      p = 32'h3000 + 32'(4 * k);
      checks++;
      if (im.im_req !== 1'b1 || im.im_addr !== p || fetch_valid !== 1'b0) begin
        failures++;
        $display("FAIL seq_fetch%0d got=%b/%h/%b exp=1/%h/0",
                 k, im.im_req, im.im_addr, fetch_valid, p);
      end
      tick();
      checks++;
      if (im.im_req !== 1'b1 || fetch_valid !== 1'b0) begin
        failures++;
        $display("FAIL seq_wait%0d got=%b/%b exp=1/0",
                 k, im.im_req, fetch_valid);
      end
      im.im_ack = 1'b1;
      im.im_rdata = mem_data(p);
      tick();
      im.im_ack = 1'b0;
      checks++;
      if (fetch_valid !== 1'b1 || PC_F !== p
          || instr_F !== mem_data(p) || ExcCodeF !== 5'd0) begin
        failures++;
        $display("FAIL seq_valid%0d got=%b/%h/%h exp=1/%h/%h",
                 k, fetch_valid, PC_F, instr_F, p, mem_data(p));
      end
      checks++;
      if (PC8_F !== p + 32'd8) begin
        failures++;
        $display("FAIL seq_pc8_%0d got=%h exp=%h", k, PC8_F, p + 32'd8);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    run_fetch(mem_data(32'h300c));
    tick();
    run_fetch(mem_data(32'h3010));
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (PC_F !== 32'h3010 || instr_F !== mem_data(32'h3010)
          || fetch_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold%0d got=%h/%h/%b exp=%h/%h/1",
                 i, PC_F, instr_F, fetch_valid,
                 32'h3010, mem_data(32'h3010));
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (PC_F !== 32'h3014 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got=%h/%b exp=3014/0",
               PC_F, fetch_valid);
    end
  endtask

  task automatic test_branch_exc();
    run_fetch(mem_data(32'h3014));
    br_taken = 1'b1;
    br_target = 32'h3002;
    tick();
    br_taken = 1'b0;
    checks++;
    if (PC_F !== 32'h3002 || im.im_req !== 1'b0 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL br_fetch got=%h/%b/%b exp=3002/0/0",
               PC_F, im.im_req, fetch_valid);
    end
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || ExcCodeF !== 5'd4
        || instr_F !== 32'h0 || im.im_req !== 1'b0) begin
      failures++;
      $display("FAIL exc_state got=%b/%0d/%h/%b exp=1/4/0/0",
               fetch_valid, ExcCodeF, instr_F, im.im_req);
    end
    stall = 1'b1;
    br_taken = 1'b1;
    br_target = 32'h3100;
    tick();
    checks++;
    if (PC_F !== 32'h3002 || fetch_valid !== 1'b1 || ExcCodeF !== 5'd4) begin
      failures++;
      $display("FAIL exc_stall got=%h/%b/%0d exp=3002/1/4",
               PC_F, fetch_valid, ExcCodeF);
    end
    stall = 1'b0;
    br_target = 32'h5000;
    tick();
    br_taken = 1'b0;
    checks++;
    if (PC_F !== 32'h5000 || im.im_req !== 1'b0) begin
      failures++;
      $display("FAIL hi_fetch got=%h/%b exp=5000/0", PC_F, im.im_req);
    end
    tick();
    checks++;
    if (ExcCodeF !== 5'd4 || fetch_valid !== 1'b1) begin
      failures++;
      $display("FAIL hi_exc got=%0d/%b exp=4/1", ExcCodeF, fetch_valid);
    end
    br_taken = 1'b1;
    br_target = 32'h3020;
    tick();
    br_taken = 1'b0;
    checks++;
    if (PC_F !== 32'h3020 || im.im_req !== 1'b1) begin
      failures++;
      $display("FAIL exc_exit got=%h/%b exp=3020/1", PC_F, im.im_req);
    end
  endtask

  task automatic test_int_in_wait();
    tick();
    IntReq = 1'b1;
    tick();
    IntReq = 1'b0;
    checks++;
    if (im.im_req !== 1'b1 || im.im_addr !== 32'h3020 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL iw_hold1 got=%b/%h/%b exp=1/3020/0",
               im.im_req, im.im_addr, fetch_valid);
    end
    br_taken = 1'b1;
    br_target = 32'h3500;
    tick();
    br_taken = 1'b0;
    checks++;
    if (im.im_addr !== 32'h3020 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL iw_hold2 got=%h/%b exp=3020/0",
               im.im_addr, fetch_valid);
    end
    tick();
    im.im_ack = 1'b1;
    im.im_rdata = 32'hDEAD_BEEF;
    tick();
    im.im_ack = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || im.im_req !== 1'b1
        || im.im_addr !== 32'h4180 || instr_F !== 32'h0) begin
      failures++;
      $display("FAIL iw_redirect got=%b/%b/%h/%h exp=0/1/4180/0",
               fetch_valid, im.im_req, im.im_addr, instr_F);
    end
  endtask

  task automatic test_pending_priority();
    tick();
    EPC = 32'h3040;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    IntReq = 1'b1;
    tick();
    IntReq = 1'b0;
    im.im_ack = 1'b1;
    tick();
    im.im_ack = 1'b0;
    checks++;
    if (im.im_addr !== 32'h4180 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL pend_eret_int got=%h/%b exp=4180/0",
               im.im_addr, fetch_valid);
    end
    tick();
    IntReq = 1'b1;
    tick();
    IntReq = 1'b0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    im.im_ack = 1'b1;
    tick();
    im.im_ack = 1'b0;
    checks++;
    if (im.im_addr !== 32'h4180 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL pend_int_eret got=%h/%b exp=4180/0",
               im.im_addr, fetch_valid);
    end
    tick();
    eret = 1'b1;
    im.im_ack = 1'b1;
    im.im_rdata = 32'h1234_5678;
    tick();
    eret = 1'b0;
    im.im_ack = 1'b0;
    checks++;
    if (PC_F !== 32'h3040 || fetch_valid !== 1'b0 || instr_F !== 32'h0) begin
      failures++;
      $display("FAIL eret_coinc got=%h/%b/%h exp=3040/0/0",
               PC_F, fetch_valid, instr_F);
    end
  endtask

  task automatic test_int_stall();
    run_fetch(mem_data(32'h3040));
    checks++;
    if (instr_F !== mem_data(32'h3040) || fetch_valid !== 1'b1) begin
      failures++;
      $display("FAIL is_valid got=%h/%b exp=%h/1",
               instr_F, fetch_valid, mem_data(32'h3040));
    end
    stall = 1'b1;
    IntReq = 1'b1;
    tick();
    stall = 1'b0;
    IntReq = 1'b0;
    checks++;
    if (PC_F !== 32'h4180 || im.im_req !== 1'b1
        || fetch_valid !== 1'b0 || ExcCodeF !== 5'd0) begin
      failures++;
      $display("FAIL int_stall got=%h/%b/%b/%0d exp=4180/1/0/0",
               PC_F, im.im_req, fetch_valid, ExcCodeF);
    end
  endtask

  task automatic test_back_to_back();
    run_fetch(mem_data(32'h4180));
    eret = 1'b1;
    EPC = 32'h3080;
    br_taken = 1'b1;
    br_target = 32'h3100;
    tick();
    eret = 1'b0;
    br_taken = 1'b0;
    checks++;
    if (PC_F !== 32'h3080 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL eret_over_br got=%h/%b exp=3080/0",
               PC_F, fetch_valid);
    end
    IntReq = 1'b1;
    tick();
    IntReq = 1'b0;
    checks++;
    if (PC_F !== 32'h4180 || PC8_F !== 32'h4188
        || im.im_req !== 1'b1 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL int_fetch got=%h/%h/%b/%b exp=4180/4188/1/0",
               PC_F, PC8_F, im.im_req, fetch_valid);
    end
  endtask

  task automatic test_reset_in_wait();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (PC_F !== 32'h3000 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_rst got=%h/%b exp=3000/0", PC_F, fetch_valid);
    end
    im.im_ack = 1'b1;
    im.im_rdata = 32'hBAD0_BAD0;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (im.im_req !== 1'b1 || fetch_valid !== 1'b0
        || instr_F !== 32'h0 || im.im_addr !== 32'h3000) begin
      failures++;
      $display("FAIL rst_ack_ignored got=%b/%b/%h/%h exp=1/0/0/3000",
               im.im_req, fetch_valid, instr_F, im.im_addr);
    end
    im.im_rdata = mem_data(32'h3000);
    tick();
    im.im_ack = 1'b0;
    checks++;
    if (fetch_valid !== 1'b1 || PC_F !== 32'h3000
        || instr_F !== mem_data(32'h3000)) begin
      failures++;
      $display("FAIL rst_refetch got=%b/%h/%h exp=1/3000/%h",
               fetch_valid, PC_F, instr_F, mem_data(32'h3000));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    stall = 1'b0;
    br_taken = 1'b0;
    br_target = '0;
    IntReq = 1'b0;
    eret = 1'b0;
    EPC = '0;
    im.im_ack = 1'b0;
    im.im_rdata = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_exc();
    test_int_in_wait();
    test_pending_priority();
    test_int_stall();
    test_back_to_back();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous active-high reset.
REQ-002 SHALL have: stall  in  1  hazard hold, freezes a valid fetch.
REQ-003 SHALL have: br_taken  in  1 and br_target  in  32  branch redirect from decode.
REQ-004 SHALL have: IntReq  in  1  interrupt/exception redirect; eret  in  1  return redirect; EPC  in  32  return address.
REQ-005 SHALL have: im_req  out  1 and im_addr  out  32  IM request; im_ack  in  1  IM data ready; im_rdata  in  32  IM data.
REQ-006 SHALL have: PC_F  out  32; PC8_F  out  32; instr_F  out  32; fetch_valid  out  1; ExcCodeF  out  5 (bits [6:2]).
REQ-007 SHALL use parameters: RESET_PC, default 32'h00003000, boot address; HANDLER_PC, default 32'h00004180, exception entry; PC_LO, default 32'h00003000, and PC_HI, default 32'h00004ffc, legal fetch window.

Function
REQ-008 SHALL implement states FETCH, WAIT, VALID, EXC.
REQ-009 SHALL treat PC_F as illegal when PC_F[1:0]!=0, PC_F<PC_LO or PC_F>PC_HI.
REQ-010 FETCH, legal PC: SHALL assert im_req=1, im_addr=PC_F, and go to WAIT next cycle.
REQ-011 FETCH, illegal PC: SHALL keep im_req=0 and go to EXC next cycle.
REQ-012 WAIT: SHALL hold im_req=1, im_addr=PC_F until im_ack=1; on im_ack SHALL register instr_F<=im_rdata and go to VALID.
REQ-013 VALID: SHALL drive fetch_valid=1 and ExcCodeF=0; if stall=1, SHALL hold PC_F and instr_F.
REQ-014 EXC: SHALL drive fetch_valid=1, ExcCodeF=5'd4 (AdEL), instr_F=0; stall behaviour as VALID.
REQ-015 VALID/EXC with stall=0: SHALL set PC_F<=(br_taken ? br_target : PC_F+4) and go to FETCH.
REQ-016 fetch_valid SHALL be 0 in FETCH and WAIT.
REQ-017 Redirect priority SHALL be IntReq > eret > branch/sequential; redirect target HANDLER_PC for IntReq, EPC for eret.
REQ-018 IntReq or eret in FETCH, VALID or EXC: SHALL load PC_F with the target and go to FETCH next cycle, regardless of stall; im_req SHALL stay asserted in FETCH that cycle only if the old PC was legal.
REQ-019 IntReq or eret in WAIT: SHALL latch target into a pending register (pend_valid=1) and keep the outstanding request; on im_ack SHALL discard im_rdata, load PC_F<=pending target, clear pend_valid, go to FETCH.
REQ-020 Pending overwrite: later IntReq SHALL replace a pending eret target; later eret SHALL NOT replace a pending IntReq target.
REQ-021 IntReq/eret coincident with im_ack in WAIT SHALL behave as REQ-019 in one step (data discarded, PC_F<=new target).
REQ-022 br_taken SHALL be ignored outside VALID/EXC with stall=0.
REQ-023 PC arithmetic SHALL be 32-bit modulo 2^32; PC8_F SHALL equal PC_F+8 combinationally.
REQ-024 Exactly one IM request SHALL be outstanding at a time; im_addr SHALL not change while im_req=1 and im_ack=0.

Reset
REQ-025 On reset=1, asynchronously: state=FETCH, PC_F=RESET_PC, instr_F=0, pend_valid=0, fetch_valid=0, ExcCodeF=0; im_req=1 in the first cycle after release.
REQ-026 Reset asserted during WAIT SHALL abandon the request; any im_ack after release while in FETCH SHALL be ignored.

Verification
REQ-027 Reset release, im_ack one cycle after each im_req, stall=0 -> PC_F sequence 0x3000, 0x3004, 0x3008, fetch_valid every 3rd cycle, instr_F = returned data.
REQ-028 stall=1 for 4 cycles in VALID at PC 0x3010 -> PC_F, instr_F, fetch_valid=1 unchanged; PC_F=0x3014 the cycle after stall drops.
REQ-029 br_taken=1, br_target=0x3002 in VALID -> FETCH with no im_req, EXC with ExcCodeF=4, fetch_valid=1, instr_F=0.
REQ-030 IntReq in WAIT at PC 0x3020, im_ack 3 cycles later -> data discarded, fetch_valid stays 0, next im_addr=0x4180.
REQ-031 eret (EPC=0x3040) then IntReq during same WAIT -> next im_addr=0x4180; reversed order -> still 0x4180.
REQ-032 IntReq with stall=1 in VALID -> PC_F=0x4180 next cycle, state FETCH, fetch_valid=0.
